// File: rtl/mar_mem_access_pkg.sv
// Shared types for the MAR / memory access sequencer: FSM encoding, access kind
// and default widths.
package mar_mem_access_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    ACC_RD = 1'b0,
    ACC_WR = 1'b1
  } mem_access_t;

endpackage

// File: rtl/mar_mem_access_mar_reg.sv
// Memory address register: load has priority over increment, increment wraps,
// and the value is frozen while hold is high.
module mar_mem_access_mar_reg #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (!hold) begin
      if (load)     q <= din;
      else if (inc) q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/mar_mem_access.sv
// MAR plus single-outstanding memory access sequencer with wait-state timeout.
// Handshake: a request is accepted only when busy is low; the strobe is held until
// mem_ready is seen high in ACCESS (or the timeout expires), then done pulses once.
module mar_mem_access
  import mar_mem_access_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mar_in,
  input  logic              mar_load,
  input  logic              mar_inc,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t      state, state_next;
  mem_access_t kind, kind_next;
  logic [7:0]  cnt;
  logic        accept;
  logic        timeout_hit;

  assign accept = (state == ST_IDLE) && (rd_req || wr_req);

  // The MAR updates on the same edge that accepts a request, so the
  // transaction naturally sees the loaded/incremented address.
  mar_mem_access_mar_reg #(.ADDR_W(ADDR_W)) u_mar (
    .clk  (clk),
    .rst  (rst),
    .hold (state != ST_IDLE),
    .load (mar_load),
    .inc  (mar_inc),
    .din  (mar_in),
    .q    (mem_addr)
  );

  always_comb begin
    state_next  = state;
    kind_next   = kind;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_ACCESS;
          kind_next  = rd_req ? ACC_RD : ACC_WR;
        end
      end
      ST_ACCESS: begin
        if (mem_ready) begin
          state_next = ST_DONE;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_next  = ST_DONE;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      kind      <= ACC_RD;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
    end else begin
      state     <= state_next;
      kind      <= kind_next;
      busy      <= (state_next != ST_IDLE);
      done      <= (state_next == ST_DONE);
      mem_rd    <= (state_next == ST_ACCESS) && (kind_next == ACC_RD);
      mem_wr    <= (state_next == ST_ACCESS) && (kind_next == ACC_WR);
    end
  end

  // Wait counter counts ACCESS cycles without mem_ready; cleared in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == ST_ACCESS && !mem_ready) begin
      cnt <= cnt + 8'd1;
    end else if (state == ST_DONE) begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wdata <= '0;
      rd_data   <= '0;
      err       <= 1'b0;
    end else begin
      if (accept && !rd_req)
        mem_wdata <= wr_data;
      if (state == ST_ACCESS && mem_ready && kind == ACC_RD)
        rd_data <= mem_rdata;
      if (accept)
        err <= 1'b0;
      else if (timeout_hit)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mar_mem_access.sv
// Directed plus randomized bench for mar_mem_access; a transaction-level model
// tracks MAR, rd_data, mem_wdata and err from the behavioural rules.
module tb_mar_mem_access;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mar_in;
  logic        mar_load, mar_inc, rd_req, wr_req;
  logic [15:0] wr_data;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_ready;
  logic [15:0] rd_data;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_mar, m_rd, m_wdata;
  logic        m_err;

  mar_mem_access #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mar_in(mar_in), .mar_load(mar_load), .mar_inc(mar_inc),
    .rd_req(rd_req), .wr_req(wr_req), .wr_data(wr_data), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .rd_data(rd_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mar_op(input bit ld, input bit inc, input logic [15:0] addr);
    mar_in = addr; mar_load = ld; mar_inc = inc;
    step();
    mar_load = 0; mar_inc = 0;
    if (ld) m_mar = addr;
    else if (inc) m_mar = m_mar + 16'd1;
    chk("mar_op_addr", 32'(mem_addr), 32'(m_mar));
    chk("mar_op_busy", 32'(busy), 32'd0);
  endtask

  // One full transaction: request, ACCESS with 'waits' stalls (or timeout), DONE, IDLE.
  task automatic do_txn(input bit rd, input bit wr, input bit ld, input bit inc,
                        input logic [15:0] addr, input logic [15:0] wd,
                        input logic [15:0] rdat, input int waits, input bit to,
                        input bit lock);
    bit is_rd;
    int ncyc;
    mar_in = addr; mar_load = ld; mar_inc = inc;
    rd_req = rd; wr_req = wr; wr_data = wd;
    step();
    mar_load = 0; mar_inc = 0; rd_req = 0; wr_req = 0;
    if (ld) m_mar = addr;
    else if (inc) m_mar = m_mar + 16'd1;
    is_rd = rd;
    m_err = 0;
    if (!is_rd) m_wdata = wd;
    ncyc = to ? TO : waits + 1;
    for (int c = 0; c < ncyc; c++) begin
      if (lock) begin
        mar_load = 1; mar_in = 16'h4000; wr_req = 1; rd_req = 1'($urandom_range(0, 1));
      end
      wr_data   = 16'($urandom);
      mem_ready = !to && (c == ncyc - 1);
      mem_rdata = (c == ncyc - 1) ? rdat : 16'($urandom);
      chk("acc_busy", 32'(busy), 32'd1);
      chk("acc_done", 32'(done), 32'd0);
      chk("acc_rd",   32'(mem_rd), 32'(is_rd));
      chk("acc_wr",   32'(mem_wr), 32'(!is_rd));
      chk("acc_addr", 32'(mem_addr), 32'(m_mar));
      if (!is_rd) chk("acc_wdata", 32'(mem_wdata), 32'(m_wdata));
      step();
    end
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = 16'($urandom);
    if (to) m_err = 1;
    else if (is_rd) m_rd = rdat;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy",  32'(busy), 32'd1);
    chk("done_strb",  32'({mem_rd, mem_wr}), 32'd0);
    chk("done_err",   32'(err), 32'(m_err));
    chk("done_rdata", 32'(rd_data), 32'(m_rd));
    chk("done_addr",  32'(mem_addr), 32'(m_mar));
    step();
    mar_load = 0; wr_req = 0; rd_req = 0; mem_ready = 0;
    chk("idle_done",  32'(done), 32'd0);
    chk("idle_busy",  32'(busy), 32'd0);
    chk("idle_addr",  32'(mem_addr), 32'(m_mar));
    chk("idle_rdata", 32'(rd_data), 32'(m_rd));
    if (lock) begin
      step();
      chk("lock_busy", 32'(busy), 32'd0);
      chk("lock_strb", 32'({mem_rd, mem_wr}), 32'd0);
      chk("lock_addr", 32'(mem_addr), 32'(m_mar));
    end
  endtask

  initial begin
    rst = 1; mar_in = 0; mar_load = 0; mar_inc = 0; rd_req = 0; wr_req = 0;
    wr_data = 0; mem_rdata = 0; mem_ready = 0;
    m_mar = 0; m_rd = 0; m_wdata = 0; m_err = 0;
    step(); step();
    rst = 0;
    step();
    chk("rst_addr",  32'(mem_addr), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_strb",  32'({mem_rd, mem_wr}), 32'd0);
    chk("rst_out",   32'({rd_data, mem_wdata}), 32'd0);
    chk("rst_flags", 32'({done, err}), 32'd0);

    // Load + read same cycle, zero wait states
    do_txn(1, 0, 1, 0, 16'h1234, 16'h0, 16'hBEEF, 0, 0, 0);
    // Write with 3 wait states
    do_txn(0, 1, 0, 0, 16'h0, 16'hA5A5, 16'h0, 3, 0, 0);
    // Timeout on a read: err set, rd_data kept; next read clears err
    do_txn(1, 0, 0, 1, 16'h0, 16'h0, 16'h1111, 0, 1, 0);
    do_txn(1, 0, 0, 0, 16'h0, 16'h0, 16'h2222, 1, 0, 0);
    // Wrap and priority
    mar_op(1, 0, 16'hFFFF);
    mar_op(0, 1, 16'h0);
    mar_op(1, 1, 16'h0777);
    do_txn(1, 1, 0, 1, 16'h0, 16'hDEAD, 16'h3333, 0, 0, 0);
    // Busy lockout during ACCESS and DONE
    do_txn(0, 1, 1, 0, 16'h0100, 16'h5A5A, 16'h0, 2, 0, 1);

    // Randomized transactions and MAR operations
    for (int i = 0; i < 40; i++) begin
      bit r, w;
      r = 1'($urandom_range(0, 1));
      w = !r || 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0)
        mar_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
      do_txn(r, w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             16'($urandom), 16'($urandom), 16'($urandom),
             int'($urandom_range(0, 4)), ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0));
    end

    // Async reset mid-write: strobes and state drop before the next edge
    wr_req = 1; wr_data = 16'h5A5A; mar_inc = 1;
    step();
    wr_req = 0; mar_inc = 0;
    step();
    chk("pre_rst_wr", 32'(mem_wr), 32'd1);
    rst = 1;
    #1;
    chk("rst_mid_wr",    32'(mem_wr), 32'd0);
    chk("rst_mid_busy",  32'(busy), 32'd0);
    chk("rst_mid_addr",  32'(mem_addr), 32'd0);
    chk("rst_mid_err",   32'(err), 32'd0);
    chk("rst_mid_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_mid_rdata", 32'(rd_data), 32'd0);
    @(negedge clk);
    rst = 0;
    m_mar = 0; m_rd = 0; m_wdata = 0; m_err = 0;
    step();
    chk("post_rst_busy", 32'(busy), 32'd0);
    do_txn(1, 0, 0, 1, 16'h0, 16'h0, 16'h4444, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
